// File: rtl/aes_out_serializer.sv
// AES result serializer: buffers 128-bit result blocks from the AES core in a
// small FIFO and streams each block out as four 32-bit words, MSW first, over
// a valid/ready interface.
module aes_out_serializer #(
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             AES_clk,
  input  logic             AES_rst_n,
  input  logic             AES_data_out_valid,
  input  logic [127:0]     AES_data_out,
  input  logic             clr,
  output logic [31:0]      ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);

  // Control state
  logic             valid_q;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
  logic [1:0]       idx, idx_next;
  logic [LVL_W-1:0] level, level_next;
  logic             overflow_q, overflow_next;

  // Block storage; data registers carry no reset
  logic [127:0] mem [DEPTH];
  logic [127:0] head;
  logic [31:0]  head_word [4];

  // Event decode
  logic capture;
  logic xfer;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;

  // A capture is the rising edge of the core's valid; a held valid counts once.
  assign capture = AES_data_out_valid & ~valid_q;
  assign busy    = (level != '0);
  assign xfer    = busy & ser_ready;
  assign pop     = xfer & (idx == 2'd3);
  assign full    = (level == LVL_W'(DEPTH));
  // A full FIFO still accepts a block when the head leaves on the same edge.
  assign wr_en   = capture & ~clr & (~full | pop);
  assign drop    = capture & ~clr & full & ~pop;

  // Next-state computation for pointers, word index, level and overflow flag
  always_comb begin
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    idx_next      = idx;
    level_next    = level;
    overflow_next = overflow_q;
    if (clr) begin
      // Flush abandons any partially sent block and discards a coincident capture.
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      idx_next      = 2'd0;
      level_next    = '0;
      overflow_next = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_next = wr_ptr + 1'b1;
      end
      if (xfer) begin
        // idx wraps 3 -> 0 on the final word of a block
        idx_next = idx + 2'd1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level_next = level + LVL_W'(1);
        2'b01:   level_next = level - LVL_W'(1);
        default: level_next = level;
      endcase
      if (drop) begin
        overflow_next = 1'b1;
      end
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      valid_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      idx        <= 2'd0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= AES_data_out_valid;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      idx        <= idx_next;
      level      <= level_next;
      overflow_q <= overflow_next;
    end
  end

  // Block storage write on an accepted capture
  always_ff @(posedge AES_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= AES_data_out;
    end
  end

  // Split the head block into words, word 0 being the most significant
  assign head = mem[rd_ptr];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign head_word[gi] = head[127 - 32*gi -: 32];
    end
  endgenerate

  // Outputs come from registered state only; data is forced to zero when empty
  // so that reset values hold without relying on unreset storage.
  assign ser_valid  = busy;
  assign ser_data   = busy ? head_word[idx] : 32'h0;
  assign ser_last   = busy & (idx == 2'd3);
  assign fifo_level = level;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed testbench for aes_out_serializer (DEPTH=2).
module tb_aes_out_serializer;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic [127:0] data;
  logic         clr;
  logic [31:0]  ser_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_last;
  logic [1:0]   fifo_level;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] BLK_A = 128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_00000001;
  localparam logic [127:0] BLK_B = 128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_00000002;
  localparam logic [127:0] BLK_C = 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_00000003;
  localparam logic [127:0] BLK_D = 128'hd0d0d0d0_d1d1d1d1_d2d2d2d2_d3d3d3d3;
  localparam logic [127:0] BLK_E = 128'he0e0e0e0_e1e1e1e1_e2e2e2e2_e3e3e3e3;
  localparam logic [127:0] BLK_G = 128'h01234567_89abcdef_fedcba98_76543210;

  aes_out_serializer #(.DEPTH(2)) dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_data_out_valid (valid),
    .AES_data_out       (data),
    .clr                (clr),
    .ser_data           (ser_data),
    .ser_valid          (ser_valid),
    .ser_ready          (ser_ready),
    .ser_last           (ser_last),
    .fifo_level         (fifo_level),
    .overflow           (overflow),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
    return 32'(b >> (96 - 32 * i));
  endfunction

  initial begin
    int k;
    int maxlvl;
    logic [127:0] blk;

    rst_n = 1'b1;
    valid = 1'b0;
    data = '0;
    clr = 1'b0;
    ser_ready = 1'b0;

    // Reset state, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 128'(ser_valid), 128'(0));
    check("rst_last", 128'(ser_last), 128'(0));
    check("rst_data", 128'(ser_data), 128'(0));
    check("rst_level", 128'(fifo_level), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    tick;
    rst_n = 1'b1;
    tick;

    // Single block with ready held high
    ser_ready = 1'b1;
    data = BLK1;
    valid = 1'b1;
    tick;
    valid = 1'b0;
    check("t1_valid_after_capture", 128'(ser_valid), 128'(1));
    check("t1_level", 128'(fifo_level), 128'(1));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_word%0d", i), 128'(ser_data), 128'(word_of(BLK1, i)));
      check($sformatf("t1_last%0d", i), 128'(ser_last), 128'(i == 3));
      tick;
    end
    check("t1_busy_end", 128'(busy), 128'(0));
    check("t1_level_end", 128'(fifo_level), 128'(0));

    // Backpressure: stall 5 cycles, then toggle ready
    ser_ready = 1'b0;
    tick;
    valid = 1'b1;
    tick;
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_stall%0d", i), 128'(ser_data), 128'(word_of(BLK1, 0)));
      tick;
    end
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      ser_ready = (c % 2 == 0);
      if (ser_valid && ser_ready) begin
        check($sformatf("t2_xfer%0d", k), 128'(ser_data), 128'(word_of(BLK1, k)));
        check($sformatf("t2_last%0d", k), 128'(ser_last), 128'(k == 3));
        k++;
      end
      tick;
    end
    ser_ready = 1'b0;
    check("t2_xfer_count", 128'(k), 128'(4));
    check("t2_busy_end", 128'(busy), 128'(0));

    // Held valid yields exactly one capture
    data = BLK1;
    valid = 1'b1;
    maxlvl = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    valid = 1'b0;
    check("t3_peak_level", 128'(maxlvl), 128'(1));
    check("t3_level", 128'(fifo_level), 128'(1));
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    check("t3_busy_end", 128'(busy), 128'(0));

    // Overflow: three captures into a 2-deep FIFO while stalled
    ser_ready = 1'b0;
    data = BLK_A; valid = 1'b1; tick; valid = 1'b0; tick;
    data = BLK_B; valid = 1'b1; tick; valid = 1'b0; tick;
    check("t4_ovf_before", 128'(overflow), 128'(0));
    data = BLK_C; valid = 1'b1; tick; valid = 1'b0; tick;
    check("t4_level", 128'(fifo_level), 128'(2));
    check("t4_ovf", 128'(overflow), 128'(1));
    ser_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      blk = (i < 4) ? BLK_A : BLK_B;
      check($sformatf("t4_word%0d", i), 128'(ser_data), 128'(word_of(blk, i % 4)));
      check($sformatf("t4_last%0d", i), 128'(ser_last), 128'(i % 4 == 3));
      tick;
    end
    check("t4_busy_end", 128'(busy), 128'(0));
    check("t4_ovf_sticky", 128'(overflow), 128'(1));
    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("t4_ovf_cleared", 128'(overflow), 128'(0));

    // Full FIFO with capture on the same edge as the head's last-word pop
    ser_ready = 1'b0;
    data = BLK_A; valid = 1'b1; tick; valid = 1'b0; tick;
    data = BLK_B; valid = 1'b1; tick; valid = 1'b0;
    check("t5_full", 128'(fifo_level), 128'(2));
    ser_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_a_word%0d", i), 128'(ser_data), 128'(word_of(BLK_A, i)));
      tick;
    end
    check("t5_a_last", 128'(ser_last), 128'(1));
    check("t5_a_word3", 128'(ser_data), 128'(word_of(BLK_A, 3)));
    data = BLK_C;
    valid = 1'b1;
    tick;
    valid = 1'b0;
    check("t5_ovf", 128'(overflow), 128'(0));
    check("t5_level", 128'(fifo_level), 128'(2));
    for (int i = 0; i < 8; i++) begin
      blk = (i < 4) ? BLK_B : BLK_C;
      check($sformatf("t5_word%0d", i), 128'(ser_data), 128'(word_of(blk, i % 4)));
      tick;
    end
    check("t5_busy_end", 128'(busy), 128'(0));

    // clr mid-block together with a new capture
    data = BLK_D; valid = 1'b1; tick; valid = 1'b0;
    check("t6_word0", 128'(ser_data), 128'(word_of(BLK_D, 0)));
    tick;
    check("t6_word1", 128'(ser_data), 128'(word_of(BLK_D, 1)));
    tick;
    check("t6_word2", 128'(ser_data), 128'(word_of(BLK_D, 2)));
    clr = 1'b1;
    data = BLK_E;
    valid = 1'b1;
    tick;
    clr = 1'b0;
    valid = 1'b0;
    check("t6_level", 128'(fifo_level), 128'(0));
    check("t6_valid", 128'(ser_valid), 128'(0));
    check("t6_last", 128'(ser_last), 128'(0));
    check("t6_ovf", 128'(overflow), 128'(0));
    for (int i = 0; i < 3; i++) tick;
    check("t6_discarded", 128'(busy), 128'(0));

    // Asynchronous reset mid-block
    ser_ready = 1'b0;
    data = BLK_D; valid = 1'b1; tick; valid = 1'b0;
    check("t7_pre_valid", 128'(ser_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 128'(ser_valid), 128'(0));
    check("t7_rst_data", 128'(ser_data), 128'(0));
    check("t7_rst_level", 128'(fifo_level), 128'(0));
    check("t7_rst_busy", 128'(busy), 128'(0));
    check("t7_rst_last", 128'(ser_last), 128'(0));
    // Valid already high when reset releases is captured on the first edge
    data = BLK_G;
    valid = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
    valid = 1'b0;
    check("t7_post_level", 128'(fifo_level), 128'(1));
    check("t7_post_word0", 128'(ser_data), 128'(word_of(BLK_G, 0)));
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    check("t7_busy_end", 128'(busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream of the AES core; consumes its 128-bit result (AES_data_out / AES_data_out_valid).
- Buffers up to DEPTH result blocks in a small FIFO.
- Emits each buffered block as four 32-bit words over a valid/ready stream, most-significant word first, for a 32-bit host bus or UART/DMA bridge.

Parameters:
- DEPTH, 2, number of 128-bit blocks buffered. Legal values are powers of two, at least 2.
- LVL_W, $clog2(DEPTH+1), width of the fifo_level output.

Ports:
- AES_clk  input  1  single clock; all logic is rising-edge.
- AES_rst_n  input  1  asynchronous active-low reset.
- AES_data_out_valid  input  1  result-valid from the AES core.
- AES_data_out  input  128  result block from the AES core.
- clr  input  1  synchronous flush; active high.
- ser_data  output  32  current output word.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  sink accepts the word.
- ser_last  output  1  marks the 4th word of a block.
- fifo_level  output  LVL_W  number of blocks held, including a partially sent head block.
- overflow  output  1  sticky: a block was dropped.
- busy  output  1  FIFO non-empty.

Behaviour:
- Clock and reset: one clock, AES_clk. Reset AES_rst_n is asynchronous, active-low.
- Reset values:
  - ser_valid=0, ser_last=0, ser_data=0, fifo_level=0, overflow=0, busy=0.
  - Write pointer, read pointer and word index all 0.
  - Edge register valid_q=0.
- Capture:
  - valid_q registers AES_data_out_valid every cycle.
  - A capture occurs at edge N when AES_data_out_valid=1 and valid_q=0 (rising edge). A valid held high for several cycles yields exactly one capture.
  - Because valid_q resets to 0, a valid already high at the first edge after reset is captured.
  - AES_data_out is written into the FIFO at the write pointer on edge N. The write pointer wraps modulo DEPTH.
- Output:
  - ser_valid = busy = (fifo_level != 0), driven from registered state.
  - The first word is presented in the cycle after capture edge N, so latency is 1 cycle.
  - ser_data is selected by the word index from the head block:
    - idx 0 = bits [127:96]
    - idx 1 = [95:64]
    - idx 2 = [63:32]
    - idx 3 = [31:0]
  - ser_last = ser_valid and idx==3.
- Handshake:
  - A word transfers on an edge where ser_valid and ser_ready are both 1.
  - While ser_valid=1 and ser_ready=0, ser_data and ser_last hold stable.
  - ser_ready while ser_valid=0 has no effect.
- Word sequencing:
  - A transfer at idx<3 increments idx.
  - A transfer at idx==3 sets idx=0 and pops the head: the read pointer advances and wraps, and the level decrements.
- Full FIFO:
  - A capture while fifo_level==DEPTH with no pop on the same edge: the block is dropped, overflow is set and stays set until clr or reset, and the FIFO contents are unchanged.
  - A capture coinciding with the last-word pop on the same edge is accepted: the level is unchanged and no overflow occurs.
- Simultaneous capture and non-final word transfer: both happen, and the level increments.
- Empty: the level never underflows. ser_ready is ignored when empty.
- clr (highest priority after reset):
  - On the edge where clr=1: pointers and idx go to 0, the level goes to 0, and overflow is cleared.
  - A capture on the same edge is discarded and is not counted as overflow.
  - Any in-progress block is abandoned mid-word, and no ser_last is produced for it.
  - valid_q still updates normally.
- Reset mid-stream: asynchronous clear of all state. Outputs take their reset values immediately, with no clock required.
- Stored block data registers need no reset. Only control state is reset.

Test Plan:
- Single block, ser_ready held high:
  - Stimulus: AES_data_out=128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, valid pulsed for 1 cycle.
  - Required: words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles, starting the cycle after capture.
  - ser_last only on 70b4c55a; then busy=0 and fifo_level=0.
- Backpressure:
  - Stimulus: same block, ser_ready=0 for 5 cycles, then toggling 1,0,1,...
  - Required: ser_data holds 69c4e0d8 while stalled; exactly 4 transfers in order; no duplicate or skipped word.
- Held valid:
  - Stimulus: AES_data_out_valid high for 10 cycles with a constant block.
  - Required: exactly one capture; fifo_level peaks at 1.
- Overflow (DEPTH=2, ser_ready=0):
  - Stimulus: three blocks captured — A=...0001, B=...0002, C=...0003.
  - Required: fifo_level=2, overflow=1.
  - After ser_ready=1: only A then B are emitted (8 words); overflow stays 1 until clr.
- Full plus pop coincidence:
  - Stimulus: FIFO full, third block captured on the same edge as A's ser_last transfer.
  - Required: overflow=0, level stays 2, and the output order is A, B, third block.
- clr and reset mid-block:
  - Stimulus: after 2 of 4 words are sent, assert clr for 1 cycle together with a new capture.
  - Required: level=0, ser_valid=0, overflow=0, and the new block is discarded.
  - Repeat with AES_rst_n low mid-cycle: all outputs go to their reset values asynchronously.
